// File: rtl/pipe_regfile_if.sv
// Bus between decode/write-back/hazard logic (master) and the register file (slave).
// Carries read ports, the write-back port, issue/flush and the busy flags.
interface pipe_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic                     any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, any_busy
    );
endinterface

// File: rtl/pipe_regfile.sv
// Register file with combinational read ports, one write-back port, optional
// write-to-read bypass and a per-register busy scoreboard for hazard stalls.
module pipe_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_regfile_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [ADDR_W-1:0]        rd_a;
    logic                     wr_live;
    logic                     iss_live;

    assign wr_live  = bus.wr_en  && (bus.wr_addr  != '0);
    assign iss_live = bus.iss_en && (bus.iss_addr != '0);

    // Entry 0 is held at zero so it collapses to a constant.
    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        regs_d[0] = '0;
    end

    // Flush beats issue; a same-cycle issue to the write-back target keeps busy set.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else if (iss_live) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        if (wr_live && !(bus.iss_en && (bus.iss_addr == bus.wr_addr))) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Bypass is masked during reset so reads return zero while rst is high.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        rd_a      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if (rd_a == '0) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
                rd_busy_c[k]                  = 1'b0;
            end else if ((BYPASS != 0) && !rst && bus.wr_en && (bus.wr_addr == rd_a)) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                rd_busy_c[k]                  = 1'b0;
            end else begin
                rd_data_c[k*DATA_W +: DATA_W] = regs_q[rd_a];
                rd_busy_c[k]                  = busy_q[rd_a];
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.any_busy = |busy_q;
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: a bypassing and a non-bypassing instance share
// stimulus; expected reads are queued by the driver and checked by a negedge monitor.
module tb_pipe_regfile;
    logic clk;
    logic rst;

    pipe_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    pipe_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    pipe_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_byp (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pipe_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    assign ifb.rd_addr  = ifa.rd_addr;
    assign ifb.wr_en    = ifa.wr_en;
    assign ifb.wr_addr  = ifa.wr_addr;
    assign ifb.wr_data  = ifa.wr_data;
    assign ifb.iss_en   = ifa.iss_en;
    assign ifb.iss_addr = ifa.iss_addr;
    assign ifb.flush    = ifa.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // port == -1 means an any_busy check; busy holds the expected flag
    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic exp_rd(input string n, input int d, input int p,
                          input logic [31:0] v, input logic b);
        exp_t e;
        e.name = n; e.dut = d; e.port = p; e.data = v; e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic exp_any(input string n, input int d, input logic b);
        exp_t e;
        e.name = n; e.dut = d; e.port = -1; e.data = '0; e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        ifa.wr_en  = 1'b0;
        ifa.iss_en = 1'b0;
        ifa.flush  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        ifa.rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        ifa.wr_en   = 1'b1;
        ifa.wr_addr = a;
        ifa.wr_data = v;
    endtask

    task automatic iss(input logic [4:0] a);
        ifa.iss_en   = 1'b1;
        ifa.iss_addr = a;
    endtask

    // Monitor: every negedge, compare all expectations queued for this cycle.
    initial begin
        exp_t        e;
        logic [31:0] act_d;
        logic        act_b;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (e.port < 0) begin
                    act_b = (e.dut == 0) ? ifa.any_busy : ifb.any_busy;
                    if (act_b !== e.busy) begin
                        bad++;
                        $display("FAIL %s dut%0d any_busy: got %b want %b",
                                 e.name, e.dut, act_b, e.busy);
                    end
                end else begin
                    act_d = (e.dut == 0) ? ifa.rd_data[e.port*32 +: 32] : ifb.rd_data[e.port*32 +: 32];
                    act_b = (e.dut == 0) ? ifa.rd_busy[e.port] : ifb.rd_busy[e.port];
                    if (act_d !== e.data || act_b !== e.busy) begin
                        bad++;
                        $display("FAIL %s dut%0d port%0d: got data=%h busy=%b want data=%h busy=%b",
                                 e.name, e.dut, e.port, act_d, act_b, e.data, e.busy);
                    end
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        ifa.rd_addr  = '0;
        ifa.wr_addr  = '0;
        ifa.wr_data  = '0;
        ifa.iss_addr = '0;
        idle();

        // In reset: a write to r5 must neither land nor bypass.
        wr(5'd5, 32'hFFFF_FFFF);
        iss(5'd5);
        rd(5'd5, 5'd5);
        exp_rd("in_rst_p0", 0, 0, 32'h0, 1'b0);
        exp_rd("in_rst_p1", 0, 1, 32'h0, 1'b0);
        exp_any("in_rst_any", 0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        idle();

        for (int i = 0; i < 32; i++) begin
            step();
            rd(5'(i), 5'(31 - i));
            exp_rd("rst_rd_p0", 0, 0, 32'h0, 1'b0);
            exp_rd("rst_rd_p1", 0, 1, 32'h0, 1'b0);
            exp_any("rst_any", 0, 1'b0);
        end

        step();
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd0, 5'd0);
        step();
        rd(5'd5, 5'd0);
        exp_rd("r5_read", 0, 0, 32'hDEAD_BEEF, 1'b0);
        exp_rd("r0_read", 0, 1, 32'h0, 1'b0);
        step();
        wr(5'd0, 32'h0000_1234);
        rd(5'd0, 5'd0);
        exp_rd("r0_no_bypass", 0, 0, 32'h0, 1'b0);
        step();
        exp_rd("r0_still_zero", 0, 0, 32'h0, 1'b0);
        exp_rd("r0_still_zero_nb", 1, 0, 32'h0, 1'b0);

        step();
        wr(5'd7, 32'hA5A5_A5A5);
        rd(5'd5, 5'd7);
        exp_rd("byp_r7", 0, 1, 32'hA5A5_A5A5, 1'b0);
        exp_rd("nobyp_r7_old", 1, 1, 32'h0, 1'b0);
        exp_rd("byp_r5_other", 0, 0, 32'hDEAD_BEEF, 1'b0);
        step();
        exp_rd("byp_r7_next", 0, 1, 32'hA5A5_A5A5, 1'b0);
        exp_rd("nobyp_r7_next", 1, 1, 32'hA5A5_A5A5, 1'b0);

        step();
        iss(5'd3);
        rd(5'd3, 5'd3);
        exp_rd("iss_r3_same", 0, 0, 32'h0, 1'b0);
        exp_any("iss_any_same", 0, 1'b0);
        step();
        exp_rd("iss_r3_busy", 0, 0, 32'h0, 1'b1);
        exp_any("iss_any", 0, 1'b1);
        step();
        exp_rd("iss_r3_hold", 0, 0, 32'h0, 1'b1);
        step();
        wr(5'd3, 32'h0000_0055);
        exp_rd("wb_r3_byp", 0, 0, 32'h0000_0055, 1'b0);
        exp_rd("wb_r3_nobyp", 1, 0, 32'h0, 1'b1);
        exp_any("wb_any_reg", 0, 1'b1);
        step();
        exp_rd("wb_r3_after", 0, 0, 32'h0000_0055, 1'b0);
        exp_any("wb_any_after", 0, 1'b0);
        step();
        iss(5'd3);
        wr(5'd3, 32'h0000_0066);
        exp_rd("isswb_byp", 0, 0, 32'h0000_0066, 1'b0);
        exp_rd("isswb_nobyp", 1, 0, 32'h0000_0055, 1'b0);
        step();
        exp_rd("isswb_busy", 0, 0, 32'h0000_0066, 1'b1);
        exp_rd("isswb_busy_nb", 1, 1, 32'h0000_0066, 1'b1);
        exp_any("isswb_any", 0, 1'b1);
        step();
        wr(5'd3, 32'h0000_0077);
        step();
        exp_rd("r3_cleared", 0, 0, 32'h0000_0077, 1'b0);
        exp_any("r3_cleared_any", 0, 1'b0);

        step();
        iss(5'd1);
        step();
        iss(5'd2);
        step();
        iss(5'd9);
        step();
        iss(5'd4);
        ifa.flush = 1'b1;
        rd(5'd9, 5'd4);
        exp_rd("pre_flush_r9", 0, 0, 32'h0, 1'b1);
        exp_rd("pre_flush_r4", 0, 1, 32'h0, 1'b0);
        exp_any("pre_flush_any", 0, 1'b1);
        step();
        exp_rd("flush_r9", 0, 0, 32'h0, 1'b0);
        exp_rd("flush_r4", 0, 1, 32'h0, 1'b0);
        exp_any("flush_any", 0, 1'b0);
        step();
        rd(5'd1, 5'd2);
        exp_rd("flush_r1", 0, 0, 32'h0, 1'b0);
        exp_rd("flush_r2", 0, 1, 32'h0, 1'b0);

        step();
        iss(5'd5);
        step();
        rd(5'd5, 5'd0);
        exp_rd("pre_rst_r5", 0, 0, 32'hDEAD_BEEF, 1'b1);
        exp_any("pre_rst_any", 0, 1'b1);
        step();
        rst = 1'b1;
        wr(5'd5, 32'hFFFF_FFFF);
        iss(5'd5);
        rd(5'd5, 5'd5);
        exp_rd("mid_rst_p0", 0, 0, 32'h0, 1'b0);
        exp_rd("mid_rst_p1", 0, 1, 32'h0, 1'b0);
        exp_rd("mid_rst_nb", 1, 0, 32'h0, 1'b0);
        exp_any("mid_rst_any", 0, 1'b0);
        step();
        exp_rd("hold_rst_r5", 0, 0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        exp_rd("post_rst_r5", 0, 0, 32'h0, 1'b0);
        exp_any("post_rst_any", 0, 1'b0);
        step();
        wr(5'd5, 32'h0BAD_F00D);
        rd(5'd5, 5'd0);
        exp_rd("post_wr_byp", 0, 0, 32'h0BAD_F00D, 1'b0);
        exp_rd("post_wr_nobyp", 1, 0, 32'h0, 1'b0);
        step();
        exp_rd("post_rd_r5", 0, 0, 32'h0BAD_F00D, 1'b0);
        exp_rd("post_rd_r5_nb", 1, 0, 32'h0BAD_F00D, 1'b0);

        step();
        step();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
